alu_seq: RTL



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   op_e    : 3-bit opcode encodings (ADD..DIV)
//   state_e : top-level sequencing FSM states
//   FLAG_*  : bit positions inside the 4-bit {Z,N,C,V} flag word
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int NFLAGS = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / divider, one bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any run)
//   start      : load operands and begin a WIDTH-step run
//   is_div     : 1 = restoring divide a/b, 0 = shift-add multiply a*b
//   a, b       : operands, sampled only on start
//   done       : high during the final step; result is final after that edge
//   result     : multiply -> full product; divide -> {remainder, quotient}
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic              run_q,  run_d;
    logic              div_q,  div_d;
    logic [CW-1:0]     cnt_q,  cnt_d;
    // acc: multiply -> {partial product, remaining multiplier bits}
    //      divide   -> {partial remainder, dividend/quotient bits}
    logic [RW-1:0]     acc_q,  acc_d;
    // opnd: multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]  opnd_q, opnd_d;

    logic [WIDTH:0]    mul_sum;
    logic [RW:0]       mul_ext;
    logic [WIDTH:0]    div_rsh;
    logic [WIDTH:0]    div_diff;

    assign done   = run_q && (cnt_q == LAST);
    assign result = acc_q;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right (carry enters at the top).
    assign mul_sum = {1'b0, acc_q[RW-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_ext = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:0]}
                              : {1'b0, acc_q};

    // Divide step: shift the next dividend bit into the remainder and
    // trial-subtract; a borrow in bit WIDTH means restore.
    assign div_rsh  = {acc_q[RW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_rsh - {1'b0, opnd_q};

    always_comb begin
        run_d  = run_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (start) begin
            run_d  = 1'b1;
            div_d  = is_div;
            cnt_d  = '0;
            acc_d  = is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd_d = is_div ? b : a;
        end else if (run_q) begin
            if (div_q) begin
                if (!div_diff[WIDTH])
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {div_rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = mul_ext[RW:1];
            end
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            run_q  <= run_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU between decode and writeback.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : instruction handshake, inst = {op, A, B}
//   out_valid/out_ready : result handshake; R/flags held until consumed
//   R                   : 2*WIDTH-bit result
//   flags               : {Z,N,C,V}
//   busy                : iterative MUL/DIV sequence in progress
// Logic/add/shift ops and divide-by-zero complete in one clock; MUL and
// DIV take WIDTH+1 clocks from accept to out_valid.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW+2*WIDTH-1:0]   inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       R,
    output logic [NFLAGS-1:0]        flags,
    output logic                     busy
);

    localparam int RW = 2 * WIDTH;
    localparam int IW = OPW + 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              out_valid_q, out_valid_d;
    logic              is_div_q, is_div_d;

    logic [OPW-1:0]    op_raw;
    op_e               op;
    logic              is_nop;
    logic [WIDTH-1:0]  a_in, b_in;

    logic              accept, consume;
    logic              go_mul, go_div;

    logic [WIDTH:0]    add_s;
    logic [WIDTH-1:0]  sub_s;
    logic [SW-1:0]     sh;
    logic [RW-1:0]     shl_ext;
    logic [RW-1:0]     sc_r;
    logic [NFLAGS-1:0] sc_f;
    logic [NFLAGS-1:0] md_f;

    logic              md_done;
    logic [RW-1:0]     md_res;

    // ---------------- decode ----------------
    assign op_raw = inst[IW-1 -: OPW];
    assign op     = op_e'(op_raw[2:0]);
    // Codes above the eight defined ones only exist when OPW > 3.
    assign is_nop = (32'(op_raw) >= 32'd8);
    assign a_in   = inst[RW-1:WIDTH];
    assign b_in   = inst[WIDTH-1:0];

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    // Divide by zero is answered immediately, so it never starts the iterator.
    assign go_mul = accept && !is_nop && (op == OP_MUL);
    assign go_div = accept && !is_nop && (op == OP_DIV) && (b_in != '0);

    // ---------------- single-cycle datapath ----------------
    assign add_s   = {1'b0, a_in} + {1'b0, b_in};
    assign sub_s   = a_in - b_in;
    assign sh      = b_in[SW-1:0];
    assign shl_ext = RW'(a_in) << sh;

    always_comb begin
        sc_r = '0;
        sc_f = '0;
        case (op)
            OP_ADD: begin
                sc_r         = RW'(add_s);
                sc_f[FLAG_C] = add_s[WIDTH];
                sc_f[FLAG_V] = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                               (add_s[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                sc_r         = RW'(sub_s);
                sc_f[FLAG_C] = (a_in < b_in);
                sc_f[FLAG_V] = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                               (sub_s[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND: sc_r = RW'(a_in & b_in);
            OP_OR:  sc_r = RW'(a_in | b_in);
            OP_XOR: sc_r = RW'(a_in ^ b_in);
            OP_SHL: begin
                sc_r = RW'(shl_ext[WIDTH-1:0]);
                // Bit WIDTH of the widened shift is the last bit pushed out.
                sc_f[FLAG_C] = (sh != '0) && shl_ext[WIDTH];
            end
            OP_DIV: begin
                // Only reaches the result path when B is zero.
                sc_r         = {a_in, {WIDTH{1'b1}}};
                sc_f[FLAG_V] = 1'b1;
            end
            default: sc_r = '0;
        endcase
        sc_f[FLAG_Z] = (sc_r[WIDTH-1:0] == '0);
        sc_f[FLAG_N] = sc_r[WIDTH-1];
        if (is_nop) begin
            sc_r         = '0;
            sc_f         = '0;
            sc_f[FLAG_Z] = 1'b1;
        end
    end

    // ---------------- iterative MUL/DIV ----------------
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (go_mul || go_div),
        .is_div (go_div),
        .a      (a_in),
        .b      (b_in),
        .done   (md_done),
        .result (md_res)
    );

    // MUL reports Z/N over the full product; DIV over the quotient.
    always_comb begin
        md_f = '0;
        if (is_div_q) begin
            md_f[FLAG_Z] = (md_res[WIDTH-1:0] == '0);
            md_f[FLAG_N] = md_res[WIDTH-1];
        end else begin
            md_f[FLAG_Z] = (md_res == '0);
            md_f[FLAG_N] = md_res[RW-1];
        end
    end

    // ---------------- sequencing FSM ----------------
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        is_div_d    = is_div_q;
        if (consume)
            out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_mul) begin
                    state_d  = S_MUL;
                    is_div_d = 1'b0;
                end else if (go_div) begin
                    state_d  = S_DIV;
                    is_div_d = 1'b1;
                end else if (accept) begin
                    r_d         = sc_r;
                    flags_d     = sc_f;
                    out_valid_d = 1'b1;
                end
            end
            S_MUL, S_DIV: begin
                if (md_done)
                    state_d = S_DONE;
            end
            S_DONE: begin
                r_d         = md_res;
                flags_d     = md_f;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            is_div_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            is_div_q    <= is_div_d;
        end
    end

    assign R         = r_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule
